display_seq_ctrl: RTL and testbench

DISPLAY_SEQ_CTRL -- requirements
Module: display_seq_ctrl

---
 rtl/display_seq_ctrl_pkg.sv | 47 ++++
 rtl/display_seq_ctrl_bcd2_counter.sv | 30 +++
 rtl/display_seq_ctrl.sv | 113 +++++++++++
 tb/tb_display_seq_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/display_seq_ctrl_pkg.sv
// Shared constants for the display sequencer: state codes, default dwell/flash
// lengths and the BCD helpers used by the controller, display mux and benches.
package display_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_SET_X       = 3'd0,
        ST_SET_Y       = 3'd1,
        ST_SHOW_LO     = 3'd2,
        ST_SHOW_HI     = 3'd3,
        ST_FLASH_Y_ON  = 3'd4,
        ST_FLASH_Y_OFF = 3'd5,
        ST_FLASH_X_ON  = 3'd6,
        ST_FLASH_X_OFF = 3'd7
    } seq_state_e;

    localparam int unsigned DWELL_DEF = 3;
    localparam int unsigned FLASH_DEF = 6;
    localparam int unsigned TCNT_W    = 3;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    // Digits are clamped with >= so a corrupted digit can never count past 9.
    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.units >= 4'd9) begin
            r.units = 4'd0;
            r.tens  = (v.tens >= 4'd9) ? 4'd0 : v.tens + 4'd1;
        end else begin
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

    // Packed BCD orders the same way as the decimal value it encodes.
    function automatic logic bcd2_lt(input bcd2_t a, input bcd2_t b);
        return {a.tens, a.units} < {b.tens, b.units};
    endfunction

    function automatic logic [TCNT_W-1:0] tcnt_sat_inc(input logic [TCNT_W-1:0] c);
        return (c == {TCNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/display_seq_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter (00..99, wraps to 00) with synchronous clear.
module bcd2_counter
    import display_seq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] units,
    output logic [3:0] tens
);

    bcd2_t nxt;

    assign nxt = bcd2_inc('{tens: tens, units: units});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            units <= 4'd0;
            tens  <= 4'd0;
        end else if (clr) begin
            units <= 4'd0;
            tens  <= 4'd0;
        end else if (inc) begin
            units <= nxt.units;
            tens  <= nxt.tens;
        end
    end

endmodule

// File: rtl/display_seq_ctrl.sv
// Display sequencer: edit X and Y, show the low/high phases for DWELL ticks,
// then flash whichever operand is larger-or-equal-side for FLASH tick phases.
module display_seq_ctrl
    import display_seq_ctrl_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEF,
    parameter int unsigned FLASH = FLASH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_clr,
    output logic [3:0] state,
    output logic [3:0] x1,
    output logic [3:0] x2,
    output logic [3:0] y1,
    output logic [3:0] y2,
    output logic       x_lt_y
);

    // DWELL and FLASH must each fit the 3-bit counter (1..7).
    localparam logic [TCNT_W-1:0] DWELL_LAST = TCNT_W'(DWELL - 1);
    localparam logic [TCNT_W-1:0] FLASH_LAST = TCNT_W'(FLASH - 1);

    seq_state_e        st;
    logic [TCNT_W-1:0] tcnt;
    logic              inc_x;
    logic              inc_y;
    bcd2_t             x_val;
    bcd2_t             y_val;

    assign state = {1'b0, st};
    assign x_val = '{tens: x2, units: x1};
    assign y_val = '{tens: y2, units: y1};

    // btn_inc is the lowest-priority pulse: any clear or advance masks it.
    assign inc_x = btn_inc && !btn_clr && !btn_next && (st == ST_SET_X);
    assign inc_y = btn_inc && !btn_clr && !btn_next && (st == ST_SET_Y);

    bcd2_counter u_x (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_x),
        .clr   (btn_clr),
        .units (x1),
        .tens  (x2)
    );

    bcd2_counter u_y (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_y),
        .clr   (btn_clr),
        .units (y1),
        .tens  (y2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_SET_X;
            tcnt   <= '0;
            x_lt_y <= 1'b0;
        end else if (btn_clr) begin
            st     <= ST_SET_X;
            tcnt   <= '0;
            x_lt_y <= 1'b0;
        end else if (btn_next) begin
            tcnt <= '0;
            case (st)
                ST_SET_X: st <= ST_SET_Y;
                ST_SET_Y: begin
                    st     <= ST_SHOW_LO;
                    x_lt_y <= bcd2_lt(x_val, y_val);
                end
                default:  st <= ST_SET_X;
            endcase
        end else if (tick) begin
            case (st)
                ST_SHOW_LO: begin
                    if (tcnt == DWELL_LAST) begin
                        st   <= ST_SHOW_HI;
                        tcnt <= '0;
                    end else begin
                        tcnt <= tcnt_sat_inc(tcnt);
                    end
                end
                ST_SHOW_HI: begin
                    if (tcnt == DWELL_LAST) begin
                        st   <= x_lt_y ? ST_FLASH_Y_ON : ST_FLASH_X_ON;
                        tcnt <= '0;
                    end else begin
                        tcnt <= tcnt_sat_inc(tcnt);
                    end
                end
                // The on/off pair is one flash phase; toggling keeps the count
                // so the whole flash lasts FLASH ticks from entry.
                ST_FLASH_Y_ON, ST_FLASH_Y_OFF, ST_FLASH_X_ON, ST_FLASH_X_OFF: begin
                    if (tcnt == FLASH_LAST) begin
                        st   <= ST_SET_X;
                        tcnt <= '0;
                    end else begin
                        st   <= seq_state_e'({st[2:1], ~st[0]});
                        tcnt <= tcnt_sat_inc(tcnt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_seq_ctrl.sv
// Scoreboard bench: each stimulus cycle queues its expected outputs, a monitor
// pops and compares them just after the clock edge that applies the stimulus.
module tb_display_seq_ctrl;
    import display_seq_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [7:0] x;
        logic [7:0] y;
        logic       lt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, btn_next, btn_inc, btn_clr;
    logic [3:0] state, x1, x2, y1, y2;
    logic       x_lt_y;

    exp_t  sb_q[$];
    string nm_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    display_seq_ctrl #(.DWELL(DWELL_DEF), .FLASH(FLASH_DEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .btn_next (btn_next),
        .btn_inc  (btn_inc),
        .btn_clr  (btn_clr),
        .state    (state),
        .x1       (x1),
        .x2       (x2),
        .y1       (y1),
        .y2       (y2),
        .x_lt_y   (x_lt_y)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic exp_t got();
        return exp_t'{state, {x2, x1}, {y2, y1}, x_lt_y};
    endfunction

    task automatic compare(input string nm, input exp_t a, input exp_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got st=%0d x=%h y=%h lt=%0d, want st=%0d x=%h y=%h lt=%0d",
                     nm, a.st, a.x, a.y, a.lt, e.st, e.x, e.y, e.lt);
        end
    endtask

    // Drive one cycle of pulses and queue what the outputs must be after that edge.
    task automatic step(input logic clr, input logic nxt, input logic inc, input logic tk,
                        input int est, input int ex, input int ey, input logic elt,
                        input string nm);
        @(negedge clk);
        btn_clr  = clr;
        btn_next = nxt;
        btn_inc  = inc;
        tick     = tk;
        sb_q.push_back(exp_t'{4'(est), bcd(ex), bcd(ey), elt});
        nm_q.push_back(nm);
    endtask

    always @(posedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string nm;
            #2;
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            compare(nm, got(), e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq_a[6];
        int seq_b[6];
        rst_n = 1'b0; tick = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_clr = 1'b0;
        repeat (2) @(negedge clk);
        compare("reset_state", got(), exp_t'{4'd0, 8'h00, 8'h00, 1'b0});
        rst_n = 1'b1;

        // Twelve increments in SET_X, then a tick that must be ignored there.
        for (int i = 1; i <= 12; i++) step(0, 0, 1, 0, 0, i, 0, 0, "inc_x12");
        step(0, 0, 0, 1, 0, 12, 0, 0, "tick_in_set_x");

        // X=05 < Y=12: low/high dwell then the Y flash pair.
        step(1, 0, 0, 0, 0, 0, 0, 0, "clr");
        for (int i = 1; i <= 5; i++) step(0, 0, 1, 0, 0, i, 0, 0, "inc_x5");
        step(0, 1, 0, 0, 1, 5, 0, 0, "next_to_set_y");
        for (int i = 1; i <= 12; i++) step(0, 0, 1, 0, 1, 5, i, 0, "inc_y12");
        step(0, 1, 0, 0, 2, 5, 12, 1, "next_to_show_lo_lt");
        step(0, 0, 1, 0, 2, 5, 12, 1, "inc_ignored_show_lo");
        step(0, 0, 0, 0, 2, 5, 12, 1, "idle_show_lo");
        seq_a = '{2, 2, 3, 3, 3, 4};
        seq_b = '{5, 4, 5, 4, 5, 0};
        foreach (seq_a[i]) step(0, 0, 0, 1, seq_a[i], 5, 12, 1, "dwell_lt");
        foreach (seq_b[i]) step(0, 0, 0, 1, seq_b[i], 5, 12, 1, "flash_y");

        // X=30 >= Y=12: flash X pair, operands kept afterwards.
        step(1, 0, 0, 0, 0, 0, 0, 0, "clr2");
        for (int i = 1; i <= 30; i++) step(0, 0, 1, 0, 0, i, 0, 0, "inc_x30");
        step(0, 1, 0, 0, 1, 30, 0, 0, "next_set_y2");
        for (int i = 1; i <= 12; i++) step(0, 0, 1, 0, 1, 30, i, 0, "inc_y12b");
        step(0, 1, 0, 0, 2, 30, 12, 0, "next_show_lo_ge");
        seq_a = '{2, 2, 3, 3, 3, 6};
        seq_b = '{7, 6, 7, 6, 7, 0};
        foreach (seq_a[i]) step(0, 0, 0, 1, seq_a[i], 30, 12, 0, "dwell_ge");
        foreach (seq_b[i]) step(0, 0, 0, 1, seq_b[i], 30, 12, 0, "flash_x");

        // next+inc in SET_Y advances without touching Y; next aborts mid-dwell.
        step(0, 1, 0, 0, 1, 30, 12, 0, "next_set_y3");
        step(0, 1, 1, 0, 2, 30, 12, 0, "next_inc_same_clk");
        step(0, 0, 0, 1, 2, 30, 12, 0, "tick_lo_1");
        step(0, 1, 0, 1, 0, 30, 12, 0, "next_beats_tick");
        step(0, 1, 0, 0, 1, 30, 12, 0, "next_set_y4");
        step(0, 1, 0, 0, 2, 30, 12, 0, "next_show_lo4");
        // Dwell restarts from entry after the abort.
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 2, 30, 12, 0, "dwell_restart");
        step(0, 0, 0, 1, 3, 30, 12, 0, "dwell_restart_hi");
        step(0, 1, 0, 0, 0, 30, 12, 0, "next_from_show_hi");

        // Clear beats tick in a flash-off state.
        step(1, 0, 0, 0, 0, 0, 0, 0, "clr3");
        step(0, 0, 1, 0, 0, 1, 0, 0, "inc_x1");
        step(0, 1, 0, 0, 1, 1, 0, 0, "next_set_y5");
        step(0, 0, 1, 0, 1, 1, 1, 0, "inc_y1");
        step(0, 0, 1, 0, 1, 1, 2, 0, "inc_y2");
        step(0, 1, 0, 0, 2, 1, 2, 1, "next_show_lo5");
        seq_a = '{2, 2, 3, 3, 3, 4};
        foreach (seq_a[i]) step(0, 0, 0, 1, seq_a[i], 1, 2, 1, "dwell_to_4");
        step(0, 0, 0, 1, 5, 1, 2, 1, "flash_to_5");
        step(1, 0, 0, 1, 0, 0, 0, 0, "clr_tick_in_5");

        // 99 -> 00 wrap on both operands; clear beats next and inc together.
        for (int i = 1; i <= 99; i++) step(0, 0, 1, 0, 0, i, 0, 0, "inc_x99");
        step(0, 0, 1, 0, 0, 0, 0, 0, "x_wrap");
        step(0, 1, 0, 0, 1, 0, 0, 0, "next_set_y6");
        for (int i = 1; i <= 99; i++) step(0, 0, 1, 0, 1, 0, i, 0, "inc_y99");
        step(0, 0, 1, 0, 1, 0, 0, 0, "y_wrap");
        step(0, 0, 1, 0, 1, 0, 1, 0, "inc_y_after_wrap");
        step(1, 1, 1, 0, 0, 0, 0, 0, "clr_beats_all");

        // Asynchronous reset mid-cycle while in SHOW_HI.
        step(0, 0, 1, 0, 0, 1, 0, 0, "pre_rst_inc_x");
        step(0, 1, 0, 0, 1, 1, 0, 0, "pre_rst_next");
        step(0, 0, 1, 0, 1, 1, 1, 0, "pre_rst_inc_y");
        step(0, 0, 1, 0, 1, 1, 2, 0, "pre_rst_inc_y2");
        step(0, 1, 0, 0, 2, 1, 2, 1, "pre_rst_show_lo");
        seq_a = '{2, 2, 3, 3, 3, 3};
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, seq_a[i], 1, 2, 1, "pre_rst_dwell");
        step(0, 0, 0, 0, 3, 1, 2, 1, "pre_rst_idle");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compare("async_reset_in_3", got(), exp_t'{4'd0, 8'h00, 8'h00, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 0, 0, 1, 0, 0, "first_edge_after_reset");
        step(0, 0, 0, 0, 0, 1, 0, 0, "final_idle");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
